// File: rtl/roi_mask_gen_if.sv
// Bus bundle for roi_mask_gen: config writes, pixel stream, mask output and count readback.
// The master drives config and pixels. The slave (the generator) returns the mask and counts.
interface roi_mask_gen_if #(
  parameter int unsigned X_W   = 10,
  parameter int unsigned Y_W   = 10,
  parameter int unsigned N_REG = 4,
  parameter int unsigned CNT_W = 19
) ();
  localparam int unsigned SEL_W = (N_REG > 1) ? $clog2(N_REG) : 1;
  localparam int unsigned B_W   = (X_W > Y_W) ? X_W : Y_W;

  logic             cfg_we;
  logic [SEL_W+1:0] cfg_addr;
  logic [B_W-1:0]   cfg_wdata;
  logic             frame_start;
  logic             pix_valid;
  logic [X_W-1:0]   tv_x;
  logic [Y_W-1:0]   tv_y;
  logic             pix_fg;
  logic [N_REG-1:0] mask;
  logic             mask_valid;
  logic [SEL_W-1:0] cnt_sel;
  logic [CNT_W-1:0] cnt_out;
  logic             cnt_valid;

  modport master (
    output cfg_we, cfg_addr, cfg_wdata, frame_start, pix_valid, tv_x, tv_y, pix_fg, cnt_sel,
    input  mask, mask_valid, cnt_out, cnt_valid
  );

  modport slave (
    input  cfg_we, cfg_addr, cfg_wdata, frame_start, pix_valid, tv_x, tv_y, pix_fg, cnt_sel,
    output mask, mask_valid, cnt_out, cnt_valid
  );
endinterface

// File: rtl/roi_mask_gen.sv
// Region-of-interest mask generator: N_REG runtime windows tested per pixel.
// It also keeps per-frame saturating foreground counts, which are latched at each frame boundary.
module roi_mask_gen #(
  parameter int unsigned X_W   = 10,
  parameter int unsigned Y_W   = 10,
  parameter int unsigned N_REG = 4,
  parameter int unsigned CNT_W = 19
) (
  input logic          clk,
  input logic          rst_n,
  roi_mask_gen_if.slave bus
);
  localparam int unsigned SEL_W = (N_REG > 1) ? $clog2(N_REG) : 1;

  logic [X_W-1:0] sh_x0_q [N_REG];
  logic [X_W-1:0] sh_x1_q [N_REG];
  logic [Y_W-1:0] sh_y0_q [N_REG];
  logic [Y_W-1:0] sh_y1_q [N_REG];
  logic [X_W-1:0] ac_x0_q [N_REG];
  logic [X_W-1:0] ac_x1_q [N_REG];
  logic [Y_W-1:0] ac_y0_q [N_REG];
  logic [Y_W-1:0] ac_y1_q [N_REG];

  logic [SEL_W-1:0] cfg_idx;
  logic [1:0]       cfg_fld;
  logic [N_REG-1:0] hit;

  logic [N_REG-1:0] mask_q;
  logic             mask_valid_q;
  logic             fg_q;
  logic             fs_q;
  logic [CNT_W-1:0] run_q [N_REG];
  logic [CNT_W-1:0] lat_q [N_REG];
  logic             cnt_valid_q;

  assign cfg_idx = bus.cfg_addr[SEL_W+1:2];
  assign cfg_fld = bus.cfg_addr[1:0];

  // A write landing with frame_start goes to shadow only; active copies the old shadow value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_REG; i++) begin
        sh_x0_q[i] <= '1;
        sh_x1_q[i] <= '0;
        sh_y0_q[i] <= '1;
        sh_y1_q[i] <= '0;
        ac_x0_q[i] <= '1;
        ac_x1_q[i] <= '0;
        ac_y0_q[i] <= '1;
        ac_y1_q[i] <= '0;
      end
    end else begin
      if (bus.frame_start) begin
        for (int i = 0; i < N_REG; i++) begin
          ac_x0_q[i] <= sh_x0_q[i];
          ac_x1_q[i] <= sh_x1_q[i];
          ac_y0_q[i] <= sh_y0_q[i];
          ac_y1_q[i] <= sh_y1_q[i];
        end
      end
      if (bus.cfg_we) begin
        for (int i = 0; i < N_REG; i++) begin
          if (int'(cfg_idx) == i) begin
            case (cfg_fld)
              2'd0:    sh_x0_q[i] <= bus.cfg_wdata[X_W-1:0];
              2'd1:    sh_x1_q[i] <= bus.cfg_wdata[X_W-1:0];
              2'd2:    sh_y0_q[i] <= bus.cfg_wdata[Y_W-1:0];
              default: sh_y1_q[i] <= bus.cfg_wdata[Y_W-1:0];
            endcase
          end
        end
      end
    end
  end

  // The first pixel of a frame is tested against the bounds being loaded that cycle.
  always_comb begin
    hit = '0;
    for (int i = 0; i < N_REG; i++) begin
      hit[i] = (bus.tv_x >= (bus.frame_start ? sh_x0_q[i] : ac_x0_q[i])) &&
               (bus.tv_x <= (bus.frame_start ? sh_x1_q[i] : ac_x1_q[i])) &&
               (bus.tv_y >= (bus.frame_start ? sh_y0_q[i] : ac_y0_q[i])) &&
               (bus.tv_y <= (bus.frame_start ? sh_y1_q[i] : ac_y1_q[i]));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask_q       <= '0;
      mask_valid_q <= 1'b0;
      fg_q         <= 1'b0;
      fs_q         <= 1'b0;
    end else begin
      mask_q       <= bus.pix_valid ? hit : '0;
      mask_valid_q <= bus.pix_valid;
      fg_q         <= bus.pix_fg;
      fs_q         <= bus.frame_start;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_valid_q <= 1'b0;
      for (int i = 0; i < N_REG; i++) begin
        run_q[i] <= '0;
        lat_q[i] <= '0;
      end
    end else begin
      cnt_valid_q <= fs_q;
      for (int i = 0; i < N_REG; i++) begin
        if (fs_q) begin
          lat_q[i] <= run_q[i];
          run_q[i] <= (mask_valid_q && fg_q && mask_q[i]) ? CNT_W'(1) : '0;
        end else if (mask_valid_q && fg_q && mask_q[i] && (run_q[i] != '1)) begin
          run_q[i] <= run_q[i] + CNT_W'(1);
        end
      end
    end
  end

  always_comb begin
    bus.cnt_out = '0;
    for (int i = 0; i < N_REG; i++) begin
      if (int'(bus.cnt_sel) == i) bus.cnt_out = lat_q[i];
    end
  end

  assign bus.mask       = mask_q;
  assign bus.mask_valid = mask_valid_q;
  assign bus.cnt_valid  = cnt_valid_q;
endmodule

// File: tb/tb_roi_mask_gen.sv
// Self-checking bench for roi_mask_gen: directed frames plus random bounds/foreground.
// Expected values come from a per-frame region/count model.
module tb_roi_mask_gen;
  localparam int unsigned XW = 10;
  localparam int unsigned YW = 10;
  localparam int unsigned N  = 4;
  localparam int unsigned CW = 8;
  localparam int MAXC = (1 << CW) - 1;
  localparam int XMAX = (1 << XW) - 1;
  localparam int YMAX = (1 << YW) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #10 clk = ~clk;

  roi_mask_gen_if #(.X_W(XW), .Y_W(YW), .N_REG(N), .CNT_W(CW)) bif ();

  roi_mask_gen #(.X_W(XW), .Y_W(YW), .N_REG(N), .CNT_W(CW)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif.slave)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Model state: bounds as {x0, x1, y0, y1}, per-frame counts, and latched snapshots awaiting readout.
  int sh [N][4];
  int ac [N][4];
  int cnt [N];
  logic prev_fs;
  logic [N*CW-1:0] lq [$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [N-1:0] hit(input int x, input int y, input logic use_sh);
    logic [N-1:0] h;
    for (int r = 0; r < N; r++) begin
      int b[4];
      for (int f = 0; f < 4; f++) b[f] = use_sh ? sh[r][f] : ac[r][f];
      h[r] = (x >= b[0]) && (x <= b[1]) && (y >= b[2]) && (y <= b[3]);
    end
    return h;
  endfunction

  task automatic model_reset();
    for (int r = 0; r < N; r++) begin
      sh[r][0] = XMAX; sh[r][1] = 0; sh[r][2] = YMAX; sh[r][3] = 0;
      ac[r][0] = XMAX; ac[r][1] = 0; ac[r][2] = YMAX; ac[r][3] = 0;
      cnt[r] = 0;
    end
    lq.delete();
    prev_fs = 1'b0;
  endtask

  task automatic step(input logic fs, input logic pv, input int x, input int y, input logic fg,
                      input logic we, input int addr, input int data);
    logic [N-1:0]    em;
    logic            ecv;
    logic [N*CW-1:0] pk;
    bif.frame_start = fs;
    bif.pix_valid   = pv;
    bif.tv_x        = x[XW-1:0];
    bif.tv_y        = y[YW-1:0];
    bif.pix_fg      = fg;
    bif.cfg_we      = we;
    bif.cfg_addr    = addr[3:0];
    bif.cfg_wdata   = data[9:0];
    em = pv ? hit(x, y, fs) : '0;
    if (fs) begin
      for (int r = 0; r < N; r++) begin
        pk[r*CW +: CW] = cnt[r][CW-1:0];
        cnt[r] = 0;
        for (int f = 0; f < 4; f++) ac[r][f] = sh[r][f];
      end
      lq.push_back(pk);
    end
    if (pv && fg) begin
      for (int r = 0; r < N; r++) if (em[r] && cnt[r] < MAXC) cnt[r]++;
    end
    if (we && (addr / 4) < N) sh[addr / 4][addr % 4] = data;
    ecv = prev_fs;
    prev_fs = fs;
    @(posedge clk);
    #1;
    check("mask", {bif.mask_valid, bif.mask}, {pv, em});
    check("cnt_valid", bif.cnt_valid, ecv);
    if (ecv && lq.size() > 0) begin
      pk = lq.pop_front();
      for (int r = 0; r < N; r++) begin
        bif.cnt_sel = r[1:0];
        #1;
        check("cnt_out", bif.cnt_out, pk[r*CW +: CW]);
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 0, 0);
  endtask

  task automatic cfg(input int region, input int x0, input int x1, input int y0, input int y1);
    step(1'b0, 1'b0, 0, 0, 1'b0, 1'b1, region * 4 + 0, x0);
    step(1'b0, 1'b0, 0, 0, 1'b0, 1'b1, region * 4 + 1, x1);
    step(1'b0, 1'b0, 0, 0, 1'b0, 1'b1, region * 4 + 2, y0);
    step(1'b0, 1'b0, 0, 0, 1'b0, 1'b1, region * 4 + 3, y1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("rst_mask", {bif.mask_valid, bif.mask}, '0);
    check("rst_cnt_valid", bif.cnt_valid, 1'b0);
    for (int r = 0; r < N; r++) begin
      bif.cnt_sel = r[1:0];
      #1;
      check("rst_cnt_out", bif.cnt_out, '0);
    end
    model_reset();
    rst_n = 1'b1;
    #1;
  endtask

  // The first pixel carries frame_start. Optional extras: a config write at pixel wr_at, a reset at rst_at.
  task automatic frame(input int cols, input int rows, input int stride, input logic fg_all,
                       input int wr_at, input int wr_addr, input int wr_data, input int rst_at);
    int k = 0;
    for (int r = 0; r < rows; r++) begin
      for (int c = 0; c < cols; c++) begin
        if ($urandom_range(7) == 0) idle(1);
        if (k == rst_at) do_reset();
        step(k == 0, 1'b1, c * stride, r * stride, fg_all ? 1'b1 : 1'($urandom_range(1)),
             k == wr_at, wr_addr, wr_data);
        k++;
      end
    end
  endtask

  task automatic close_frame();
    step(1'b1, 1'b0, 0, 0, 1'b0, 1'b0, 0, 0);
    idle(2);
  endtask

  task automatic cnt_is(input int sel, input int exp);
    bif.cnt_sel = sel[1:0];
    #1;
    check("cnt_latched", bif.cnt_out, exp);
  endtask

  initial begin
    bif.cfg_we = 1'b0; bif.cfg_addr = '0; bif.cfg_wdata = '0; bif.frame_start = 1'b0;
    bif.pix_valid = 1'b0; bif.tv_x = '0; bif.tv_y = '0; bif.pix_fg = 1'b0; bif.cnt_sel = '0;
    model_reset();
    @(posedge clk);
    #1;
    do_reset();

    // Power-up: sparse 640x480 raster, every region empty.
    frame(80, 60, 8, 1'b0, -1, 0, 0, -1);
    close_frame();
    for (int r = 0; r < N; r++) cnt_is(r, 0);

    // Single column window, 7 rows tall.
    cfg(0, 40, 40, 2, 8);
    frame(48, 32, 1, 1'b1, -1, 0, 0, -1);
    close_frame();
    cnt_is(0, 7);

    // Mid-frame write waits for the next frame_start. A write in the same cycle waits one more frame.
    step(1'b0, 1'b0, 0, 0, 1'b0, 1'b1, 5, 9);
    step(1'b0, 1'b0, 0, 0, 1'b0, 1'b1, 6, 0);
    step(1'b0, 1'b0, 0, 0, 1'b0, 1'b1, 7, 0);
    frame(48, 32, 1, 1'b1, 100, 4, 0, -1);
    close_frame();
    cnt_is(1, 0);
    frame(48, 32, 1, 1'b1, -1, 0, 0, -1);
    close_frame();
    cnt_is(1, 10);
    frame(48, 32, 1, 1'b1, 0, 7, 1, -1);
    close_frame();
    cnt_is(1, 10);
    frame(48, 32, 1, 1'b1, -1, 0, 0, -1);
    close_frame();
    cnt_is(1, 20);

    // All regions cover everything: overlapping mask bits, and counts saturate.
    for (int r = 0; r < N; r++) cfg(r, 0, XMAX, 0, YMAX);
    frame(48, 32, 1, 1'b1, -1, 0, 0, -1);
    close_frame();
    for (int r = 0; r < N; r++) cnt_is(r, MAXC);

    // Inverted x bounds give an empty region. Test a degenerate single-pixel region and a region with x0>x1.
    cfg(0, 100, 50, 0, YMAX);
    cfg(1, 5, 5, 7, 7);
    cfg(2, 1, 0, 0, YMAX);
    frame(48, 32, 1, 1'b1, -1, 0, 0, -1);
    close_frame();
    cnt_is(0, 0);
    cnt_is(1, 1);
    cnt_is(2, 0);
    cnt_is(3, MAXC);

    // Random windows and foreground.
    for (int it = 0; it < 3; it++) begin
      for (int r = 0; r < N; r++)
        cfg(r, $urandom_range(50), $urandom_range(50), $urandom_range(35), $urandom_range(35));
      frame(48, 32, 1, 1'b0, -1, 0, 0, -1);
      close_frame();
    end

    // Back-to-back frame_start pulses each latch and pulse.
    step(1'b1, 1'b1, 3, 3, 1'b1, 1'b0, 0, 0);
    step(1'b1, 1'b1, 4, 4, 1'b1, 1'b0, 0, 0);
    step(1'b1, 1'b1, 5, 5, 1'b1, 1'b0, 0, 0);
    close_frame();

    // Reset mid-frame, then behaviour matches power-up.
    frame(48, 32, 1, 1'b0, -1, 0, 0, 700);
    close_frame();
    for (int r = 0; r < N; r++) cnt_is(r, 0);
    cfg(0, 0, 47, 0, 0);
    frame(48, 32, 1, 1'b1, -1, 0, 0, -1);
    close_frame();
    cnt_is(0, 48);
    cnt_is(1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
